// File: rtl/rgb_blend_stream.sv
// rgb_blend_stream
//   Streaming two-image blender. Each output byte is
//     sat8( (A*wa)[15:8] + (B*wb)[15:8] )
//   where A/B are paired bytes from two valid/ready streams and wa/wb are
//   weights latched when a frame starts. A frame is NUM_PIXELS bytes
//   (R,G,B interleaved). The datapath is a 2-stage pipe advanced by a single
//   global enable, so a stalled output freezes the whole pipe and both inputs.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               start-of-frame request, honoured only in IDLE
//   weight_a/weight_b   blend weights (0x80 = 50%), latched on start
//   a_valid/a_pixel/a_ready   stream A byte handshake
//   b_valid/b_pixel/b_ready   stream B byte handshake
//   out_valid/out_pixel/out_last/out_ready  blended byte handshake;
//                       out_last marks byte NUM_PIXELS-1
//   busy                high while a frame is running or draining
//   frame_done          one-cycle pulse after the last output handshake
//
// multiplier1 is the shared 8x8 multiplier block; rgb_blend_stream uses its
// 16-bit product as-is and takes the upper byte.

module multiplier1 (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] y
);
  assign y = {8'd0, A} * {8'd0, B};
endmodule

module rgb_blend_stream #(
  parameter int NUM_PIXELS = 270000,
  parameter int CNT_W      = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] weight_a,
  input  logic [7:0] weight_b,
  input  logic       a_valid,
  input  logic [7:0] a_pixel,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_pixel,
  output logic       b_ready,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_cnt;
  logic [7:0]       wa, wb;
  logic             en, accept, at_last, last_hs;
  logic [15:0]      prod_a, prod_b;

  logic [7:0]       prod_a_p1, prod_b_p1;
  logic             vld_p1, last_p1;

  function automatic logic [7:0] sat8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  multiplier1 u_mul_a (.A(a_pixel), .B(wa), .y(prod_a));
  multiplier1 u_mul_b (.A(b_pixel), .B(wb), .y(prod_b));

  // One enable moves every stage; each ready looks only at the other
  // stream's valid so a pair is taken only when both are present.
  assign en      = !out_valid || out_ready;
  assign a_ready = (state == RUN) && en && b_valid;
  assign b_ready = (state == RUN) && en && a_valid;
  assign accept  = (state == RUN) && en && a_valid && b_valid;
  assign at_last = (in_cnt == CNT_W'(NUM_PIXELS - 1));
  assign last_hs = out_valid && out_ready && out_last;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && at_last) state_nxt = DRAIN;
      DRAIN:   if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      wa         <= '0;
      wb         <= '0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_pixel  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == DRAIN) && last_hs;
      if ((state == IDLE) && start) begin
        in_cnt <= '0;
        wa     <= weight_a;
        wb     <= weight_b;
      end else if (accept) begin
        in_cnt <= in_cnt + CNT_W'(1);
      end
      if (en) begin
        // stage 1: pair accepted, products registered
        vld_p1 <= accept;
        if (accept) last_p1 <= at_last;
        // stage 2: saturating sum presented at the output
        out_valid <= vld_p1;
        out_last  <= vld_p1 && last_p1;
        if (vld_p1) out_pixel <= sat8(prod_a_p1, prod_b_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && accept) begin
      prod_a_p1 <= prod_a[15:8];
      prod_b_p1 <= prod_b[15:8];
    end
  end

endmodule

// File: tb/tb_rgb_blend_stream.sv
// Bench for rgb_blend_stream: scoreboard of expected blended bytes pushed at
// each accepted input pair and compared against the collected output stream.

module tb_rgb_blend_stream;

  localparam int NP = 150;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] weight_a, weight_b;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_pixel, b_pixel;
  logic       out_valid, out_last, out_ready, busy, frame_done;
  logic [7:0] out_pixel;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic       obs_last[$];
  int         fd_cnt = 0;
  int         stall_viol = 0;
  int         join_viol = 0;

  rgb_blend_stream #(.NUM_PIXELS(NP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .weight_a(weight_a), .weight_b(weight_b),
    .a_valid(a_valid), .a_pixel(a_pixel), .a_ready(a_ready),
    .b_valid(b_valid), .b_pixel(b_pixel), .b_ready(b_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (a_ready === 1'b1 && b_valid !== 1'b1) join_viol++;
    if (b_ready === 1'b1 && a_valid !== 1'b1) join_viol++;
  end

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] wa, input logic [7:0] wb);
    logic [15:0] pa, pb;
    logic [8:0]  s;
    pa = {8'd0, a} * {8'd0, wa};
    pb = {8'd0, b} * {8'd0, wb};
    s  = {1'b0, pa[15:8]} + {1'b0, pb[15:8]};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  task automatic drive_start(input logic [7:0] wa, input logic [7:0] wb);
    @(posedge clk); #1;
    start = 1'b1; weight_a = wa; weight_b = wb;
    @(posedge clk); #1;
    start = 1'b0; weight_a = 8'($urandom); weight_b = 8'($urandom);
  endtask

  // pat: 0 = all zero bytes, 1 = all 0xFF, 2 = random
  task automatic run_frame(input int n, input logic [7:0] wa, input logic [7:0] wb,
                           input int pat, input bit bp, output bit timed_out);
    logic [7:0] ad[$];
    logic [7:0] bd[$];
    exp_q.delete(); obs_q.delete(); obs_last.delete();
    stall_viol = 0; join_viol = 0; fd_cnt = 0; timed_out = 1'b0;
    for (int i = 0; i < n; i++) begin
      ad.push_back(pat == 0 ? 8'h00 : pat == 1 ? 8'hFF : 8'($urandom));
      bd.push_back(pat == 0 ? 8'h00 : pat == 1 ? 8'hFF : 8'($urandom));
    end
    out_ready = 1'b1;
    drive_start(wa, wb);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int d;
          int t;
          d = bp ? int'($urandom_range(3, 0)) : 0;
          a_valid = 1'b0;
          repeat (d) begin @(posedge clk); #1; end
          a_valid = 1'b1; a_pixel = ad[i];
          t = 0;
          @(negedge clk);
          while (!a_ready && t < 1000) begin @(negedge clk); t++; end
          if (!a_ready) begin
            timed_out = 1'b1; i = n;
          end else begin
            exp_q.push_back(model(a_pixel, b_pixel, wa, wb));
            @(posedge clk); #1;
          end
        end
        a_valid = 1'b0;
      end
      begin
        for (int i = 0; i < n; i++) begin
          int d;
          int t;
          d = bp ? int'($urandom_range(1, 0)) : 0;
          b_valid = 1'b0;
          repeat (d) begin @(posedge clk); #1; end
          b_valid = 1'b1; b_pixel = bd[i];
          t = 0;
          @(negedge clk);
          while (!b_ready && t < 1000) begin @(negedge clk); t++; end
          if (!b_ready) begin
            timed_out = 1'b1; i = n;
          end else begin
            @(posedge clk); #1;
          end
        end
        b_valid = 1'b0;
      end
      begin
        int got;
        int t;
        logic [7:0] prev_pix;
        bit prev_stall;
        got = 0; t = 0; prev_stall = 1'b0; prev_pix = 8'h00;
        while (got < n && t < 40 * n + 200) begin
          @(posedge clk); #1;
          out_ready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
          @(negedge clk); t++;
          if (prev_stall && (out_valid !== 1'b1 || out_pixel !== prev_pix)) stall_viol++;
          prev_stall = (out_valid === 1'b1) && !out_ready;
          prev_pix   = out_pixel;
          if (out_valid === 1'b1 && out_ready) begin
            obs_q.push_back(out_pixel);
            obs_last.push_back(out_last);
            got++;
          end
        end
        if (got < n) timed_out = 1'b1;
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin
      start = 1'($urandom); weight_a = 8'($urandom); weight_b = 8'($urandom);
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_pixel = 8'($urandom); b_pixel = 8'($urandom); out_ready = 1'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if ({a_ready, b_ready, out_valid, out_pixel, out_last, busy, frame_done} !== 14'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got rdy=%b%b ov=%b px=%h last=%b busy=%b fd=%b, need all 0",
                 a_ready, b_ready, out_valid, out_pixel, out_last, busy, frame_done);
      end
    end
    start = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b a_ready=%b, need 0 0", busy, a_ready);
    end
  endtask

  task automatic test_midscale;
    bit to;
    run_frame(NP, 8'h80, 8'h80, 0, 1'b0, to);
    n_checks++;
    if (to || obs_q.size() != NP) begin
      n_fail++; $display("FAIL mid_count: got %0d bytes timeout=%0b, need %0d", obs_q.size(), to, NP);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== 8'h00 || obs_last[i] !== (i == NP - 1)) begin
        n_fail++;
        $display("FAIL mid_byte[%0d]: got %h last=%b, need 00 last=%b", i, obs_q[i], obs_last[i], i == NP - 1);
      end
    end
    n_checks++;
    if (fd_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_done: frame_done pulses=%0d busy=%b, need 1 and 0", fd_cnt, busy);
    end
  endtask

  task automatic test_saturation;
    bit to;
    run_frame(NP, 8'hFF, 8'hFF, 1, 1'b0, to);
    n_checks++;
    if (to || obs_q.size() != NP) begin
      n_fail++; $display("FAIL sat_count: got %0d bytes timeout=%0b, need %0d", obs_q.size(), to, NP);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== 8'hFF) begin
        n_fail++; $display("FAIL sat_byte[%0d]: got %h, need ff", i, obs_q[i]);
      end
    end
    run_frame(NP, 8'h00, 8'h00, 1, 1'b0, to);
    n_checks++;
    if (to || obs_q.size() != NP) begin
      n_fail++; $display("FAIL zero_count: got %0d bytes timeout=%0b, need %0d", obs_q.size(), to, NP);
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== 8'h00) begin
        n_fail++; $display("FAIL zero_byte[%0d]: got %h, need 00", i, obs_q[i]);
      end
    end
  endtask

  task automatic test_golden;
    bit to;
    run_frame(NP, 8'h80, 8'h80, 2, 1'b0, to);
    n_checks++;
    if (to || obs_q.size() != exp_q.size() || exp_q.size() != NP) begin
      n_fail++;
      $display("FAIL gold_count: got %0d bytes, expected %0d of %0d, timeout=%0b", obs_q.size(), exp_q.size(), NP, to);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_last[i] !== (i == NP - 1)) begin
        n_fail++;
        $display("FAIL gold_byte[%0d]: got %h last=%b, need %h last=%b", i, obs_q[i], obs_last[i], exp_q[i], i == NP - 1);
      end
    end
    n_checks++;
    if (fd_cnt != 1) begin
      n_fail++; $display("FAIL gold_done: frame_done pulses=%0d, need 1", fd_cnt);
    end
  endtask

  task automatic test_backpressure;
    bit to;
    run_frame(NP, 8'hC0, 8'h60, 2, 1'b1, to);
    n_checks++;
    if (to || obs_q.size() != exp_q.size() || exp_q.size() != NP) begin
      n_fail++;
      $display("FAIL bp_count: got %0d bytes, expected %0d of %0d, timeout=%0b", obs_q.size(), exp_q.size(), NP, to);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_last[i] !== (i == NP - 1)) begin
        n_fail++;
        $display("FAIL bp_byte[%0d]: got %h last=%b, need %h last=%b", i, obs_q[i], obs_last[i], exp_q[i], i == NP - 1);
      end
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++; $display("FAIL bp_stall_stable: %0d changes while stalled, need 0", stall_viol);
    end
    n_checks++;
    if (join_viol != 0) begin
      n_fail++; $display("FAIL bp_join: %0d ready-without-partner cycles, need 0", join_viol);
    end
    n_checks++;
    if (fd_cnt != 1) begin
      n_fail++; $display("FAIL bp_done: frame_done pulses=%0d, need 1", fd_cnt);
    end
  endtask

  task automatic test_reset_midframe;
    int acc;
    int t;
    bit to;
    out_ready = 1'b1;
    drive_start(8'h80, 8'h80);
    a_valid = 1'b1; b_valid = 1'b1; a_pixel = 8'h55; b_pixel = 8'hAA;
    acc = 0; t = 0;
    while (acc < 100 && t < 1000) begin
      @(negedge clk); t++;
      if (a_ready && a_valid) acc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (acc != 100) begin
      n_fail++; $display("FAIL rmid_accepts: got %0d accepts, need 100", acc);
    end
    fd_cnt = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({a_ready, b_ready, out_valid, out_pixel, out_last, busy, frame_done} !== 14'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got rdy=%b%b ov=%b px=%h last=%b busy=%b fd=%b, need all 0",
               a_ready, b_ready, out_valid, out_pixel, out_last, busy, frame_done);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (fd_cnt != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_no_done: frame_done pulses=%0d busy=%b, need 0 and 0", fd_cnt, busy);
    end
    run_frame(NP, 8'h80, 8'h80, 2, 1'b0, to);
    n_checks++;
    if (to || obs_q.size() != NP || exp_q.size() != NP) begin
      n_fail++; $display("FAIL rmid_fresh_count: got %0d bytes timeout=%0b, need %0d", obs_q.size(), to, NP);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_last[i] !== (i == NP - 1)) begin
        n_fail++;
        $display("FAIL rmid_fresh_byte[%0d]: got %h last=%b, need %h last=%b", i, obs_q[i], obs_last[i], exp_q[i], i == NP - 1);
      end
    end
    n_checks++;
    if (fd_cnt != 1) begin
      n_fail++; $display("FAIL rmid_fresh_done: frame_done pulses=%0d, need 1", fd_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; weight_a = 8'h00; weight_b = 8'h00;
    a_valid = 1'b0; b_valid = 1'b0; a_pixel = 8'h00; b_pixel = 8'h00; out_ready = 1'b1;
    test_reset();
    test_midscale();
    test_saturation();
    test_golden();
    test_backpressure();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
